// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU job controller and its APB engine.
package tpu_pkg;

    localparam int unsigned DW_DEF   = 32;

    localparam int unsigned ADDR_W00 = 0;
    localparam int unsigned ADDR_W01 = 1;
    localparam int unsigned ADDR_W10 = 2;
    localparam int unsigned ADDR_W11 = 3;
    localparam int unsigned ADDR_RES = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WSETUP,
        ST_WACCESS,
        ST_FEED,
        ST_RUN,
        ST_RSETUP,
        ST_RACCESS,
        ST_RHOLD
    } state_e;

    function automatic int unsigned w_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_W00;
            2'd1:    return ADDR_W01;
            2'd2:    return ADDR_W10;
            default: return ADDR_W11;
        endcase
    endfunction

endpackage

// File: rtl/tpu_apb_xfer.sv
// Two-phase APB master: a req pulse starts SETUP on the next edge; a req seen
// in ACCESS chains straight into the next SETUP so psel stays high between transfers.
module tpu_apb_xfer
    import tpu_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_write,
    output logic          o_done,
    output logic [DW-1:0] o_rdata,
    output logic          o_psel,
    output logic          o_penable,
    output logic          o_pwrite,
    output logic [AW-1:0] o_paddr,
    output logic [DW-1:0] o_pwdata,
    input  logic [DW-1:0] i_prdata
);

    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_e;

    phase_e        phase_q;
    logic          psel_q, penable_q, pwrite_q;
    logic [AW-1:0] paddr_q;
    logic [DW-1:0] pwdata_q, rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase_q   <= PH_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
        end else begin
            case (phase_q)
                PH_SETUP: begin
                    phase_q   <= PH_ACCESS;
                    penable_q <= 1'b1;
                end
                default: begin
                    if (phase_q == PH_ACCESS && !pwrite_q)
                        rdata_q <= i_prdata;
                    if (i_req) begin
                        phase_q   <= PH_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= i_write;
                        paddr_q   <= i_addr;
                        pwdata_q  <= i_wdata;
                    end else begin
                        phase_q   <= PH_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        paddr_q   <= '0;
                        pwdata_q  <= '0;
                    end
                end
            endcase
        end
    end

    assign o_done    = (phase_q == PH_ACCESS);
    assign o_rdata   = rdata_q;
    assign o_psel    = psel_q;
    assign o_penable = penable_q;
    assign o_pwrite  = pwrite_q;
    assign o_paddr   = paddr_q;
    assign o_pwdata  = pwdata_q;

endmodule

// File: rtl/tpu_job_ctrl.sv
// Job sequencer for tpu_top: weight load over APB, FIFO feed, start/done
// handshake with timeout, and a result drain of N_RES APB reads.
module tpu_job_ctrl
    import tpu_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned AW      = 32,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned N_RES   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_job_valid,
    output logic            o_job_ready,
    input  logic [4*DW-1:0] i_job_w,
    input  logic [CNT_W-1:0] i_job_nvec,
    input  logic            i_job_keep_w,
    input  logic            i_vec_valid,
    output logic            o_vec_ready,
    input  logic [DW-1:0]   i_vec_a,
    input  logic [DW-1:0]   i_vec_b,
    output logic            o_res_valid,
    input  logic            i_res_ready,
    output logic [DW-1:0]   o_res_data,
    output logic            o_res_last,
    output logic [DW-1:0]   o_in1,
    output logic [DW-1:0]   o_in2,
    output logic            o_in_en,
    input  logic [1:0]      i_in_full,
    output logic            o_start,
    input  logic            i_done,
    output logic [AW-1:0]   o_paddr,
    output logic            o_psel,
    output logic            o_penable,
    output logic            o_pwrite,
    output logic [DW-1:0]   o_pwdata,
    input  logic [DW-1:0]   i_prdata,
    output logic            o_busy,
    output logic            o_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = (N_RES > 1) ? $clog2(N_RES) : 1;

    state_e           state_q;
    logic [DW-1:0]    w_q [4];
    logic [CNT_W-1:0] nvec_q, vcnt_q;
    logic [1:0]       widx_q, widx_nx;
    logic [RW-1:0]    ridx_q;
    logic [TW-1:0]    run_cnt_q;
    logic             start_q, err_q;

    logic             push, res_last, xfer_done;
    logic             req, req_write;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata, rdata;

    assign widx_nx  = widx_q + 2'd1;
    assign push     = (state_q == ST_FEED) && i_vec_valid && (i_in_full == 2'b00);
    assign res_last = (state_q == ST_RHOLD) && (ridx_q == RW'(N_RES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            nvec_q    <= '0;
            vcnt_q    <= '0;
            widx_q    <= '0;
            ridx_q    <= '0;
            run_cnt_q <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            for (int unsigned k = 0; k < 4; k++) w_q[k] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_job_valid) begin
                    for (int unsigned k = 0; k < 4; k++) w_q[k] <= i_job_w[k*DW +: DW];
                    nvec_q    <= i_job_nvec;
                    err_q     <= 1'b0;
                    widx_q    <= '0;
                    vcnt_q    <= '0;
                    ridx_q    <= '0;
                    run_cnt_q <= '0;
                    if (!i_job_keep_w) begin
                        state_q <= ST_WSETUP;
                    end else if (i_job_nvec != '0) begin
                        state_q <= ST_FEED;
                    end else begin
                        state_q <= ST_RUN;
                        start_q <= 1'b1;
                    end
                end
                ST_WSETUP: state_q <= ST_WACCESS;
                ST_WACCESS: if (xfer_done) begin
                    if (widx_q == 2'd3) begin
                        if (nvec_q != '0) begin
                            state_q <= ST_FEED;
                        end else begin
                            state_q <= ST_RUN;
                            start_q <= 1'b1;
                        end
                    end else begin
                        widx_q  <= widx_nx;
                        state_q <= ST_WSETUP;
                    end
                end
                ST_FEED: if (push) begin
                    if (vcnt_q == nvec_q - CNT_W'(1)) begin
                        vcnt_q  <= '0;
                        state_q <= ST_RUN;
                        start_q <= 1'b1;
                    end else begin
                        vcnt_q  <= vcnt_q + CNT_W'(1);
                    end
                end
                // done is tested before the timeout so a coincident done still drains
                ST_RUN: begin
                    if (i_done) begin
                        start_q   <= 1'b0;
                        run_cnt_q <= '0;
                        state_q   <= ST_RSETUP;
                    end else if (run_cnt_q == TW'(TIMEOUT - 1)) begin
                        start_q   <= 1'b0;
                        err_q     <= 1'b1;
                        run_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        run_cnt_q <= run_cnt_q + TW'(1);
                    end
                end
                ST_RSETUP:  state_q <= ST_RACCESS;
                ST_RACCESS: if (xfer_done) state_q <= ST_RHOLD;
                ST_RHOLD: if (i_res_ready) begin
                    if (res_last) begin
                        state_q <= ST_IDLE;
                    end else begin
                        ridx_q  <= ridx_q + RW'(1);
                        state_q <= ST_RSETUP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A request issued here lands the engine in SETUP on the same edge the FSM
    // enters WSETUP/RSETUP, keeping both in lockstep.
    always_comb begin
        req       = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state_q)
            ST_IDLE: if (i_job_valid && !i_job_keep_w) begin
                req       = 1'b1;
                req_write = 1'b1;
                req_addr  = AW'(w_addr(2'd0));
                req_wdata = i_job_w[DW-1:0];
            end
            ST_WACCESS: if (xfer_done && widx_q != 2'd3) begin
                req       = 1'b1;
                req_write = 1'b1;
                req_addr  = AW'(w_addr(widx_nx));
                req_wdata = w_q[widx_nx];
            end
            ST_RUN: if (i_done) begin
                req      = 1'b1;
                req_addr = AW'(ADDR_RES);
            end
            ST_RHOLD: if (i_res_ready && !res_last) begin
                req      = 1'b1;
                req_addr = AW'(ADDR_RES);
            end
            default: ;
        endcase
    end

    tpu_apb_xfer #(.DW(DW), .AW(AW)) u_xfer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (req),
        .i_addr    (req_addr),
        .i_wdata   (req_wdata),
        .i_write   (req_write),
        .o_done    (xfer_done),
        .o_rdata   (rdata),
        .o_psel    (o_psel),
        .o_penable (o_penable),
        .o_pwrite  (o_pwrite),
        .o_paddr   (o_paddr),
        .o_pwdata  (o_pwdata),
        .i_prdata  (i_prdata)
    );

    assign o_job_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_vec_ready = (state_q == ST_FEED) && (i_in_full == 2'b00);
    assign o_in_en     = push;
    assign o_in1       = (state_q == ST_FEED) ? i_vec_a : '0;
    assign o_in2       = (state_q == ST_FEED) ? i_vec_b : '0;
    assign o_res_valid = (state_q == ST_RHOLD);
    assign o_res_data  = (state_q == ST_RHOLD) ? rdata : '0;
    assign o_res_last  = res_last;
    assign o_start     = start_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Directed bench for tpu_job_ctrl with a small APB read-data model.
module tb_tpu_job_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    logic            i_clk, i_rst;
    logic            i_job_valid, o_job_ready, i_job_keep_w;
    logic [4*DW-1:0] i_job_w;
    logic [3:0]      i_job_nvec;
    logic            i_vec_valid, o_vec_ready;
    logic [DW-1:0]   i_vec_a, i_vec_b;
    logic            o_res_valid, i_res_ready, o_res_last;
    logic [DW-1:0]   o_res_data, o_in1, o_in2;
    logic            o_in_en, o_start, i_done;
    logic [1:0]      i_in_full;
    logic [AW-1:0]   o_paddr;
    logic            o_psel, o_penable, o_pwrite;
    logic [DW-1:0]   o_pwdata, i_prdata;
    logic            o_busy, o_err;

    int errs = 0;
    int checks = 0;

    tpu_job_ctrl #(.DW(DW), .AW(AW), .CNT_W(4), .N_RES(4), .TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_job_valid(i_job_valid), .o_job_ready(o_job_ready), .i_job_w(i_job_w),
        .i_job_nvec(i_job_nvec), .i_job_keep_w(i_job_keep_w),
        .i_vec_valid(i_vec_valid), .o_vec_ready(o_vec_ready), .i_vec_a(i_vec_a), .i_vec_b(i_vec_b),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data), .o_res_last(o_res_last),
        .o_in1(o_in1), .o_in2(o_in2), .o_in_en(o_in_en), .i_in_full(i_in_full),
        .o_start(o_start), .i_done(i_done),
        .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_pwdata(o_pwdata), .i_prdata(i_prdata),
        .o_busy(o_busy), .o_err(o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // tpu_top read model: each completed read of address 0 advances the counter
    logic [15:0] rd_cnt = '0;
    always_ff @(posedge i_clk)
        if (o_psel && o_penable && !o_pwrite) rd_cnt <= rd_cnt + 16'd1;
    assign i_prdata = {16'hC0DE, rd_cnt};

    logic any_out;
    assign any_out = |{o_vec_ready, o_res_valid, o_res_data, o_res_last, o_in1, o_in2, o_in_en,
                       o_start, o_paddr, o_psel, o_penable, o_pwrite, o_pwdata, o_busy, o_err};

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_job(input logic [4*DW-1:0] w, input logic [3:0] n, input logic keep);
        i_job_valid = 1'b1; i_job_w = w; i_job_nvec = n; i_job_keep_w = keep;
        #1;
        checks++; if (o_job_ready !== 1'b1) begin errs++; $display("FAIL job_ready_idle got=%b exp=1", o_job_ready); end
        step();
        i_job_valid = 1'b0;
    endtask

    // Entered with the DUT in RSETUP; leaves it in IDLE.
    task automatic drain(input int stall_idx, input int stall_n);
        int base;
        logic [DW-1:0] exp;
        base = int'(rd_cnt);
        for (int r = 0; r < 4; r++) begin
            checks++; if ({o_psel, o_penable, o_pwrite, o_res_valid} !== 4'b1000 || o_paddr !== '0) begin
                errs++; $display("FAIL rd_setup r=%0d got=%b addr=%h exp=1000 addr=0", r, {o_psel, o_penable, o_pwrite, o_res_valid}, o_paddr); end
            step();
            checks++; if ({o_psel, o_penable, o_pwrite, o_res_valid} !== 4'b1100) begin
                errs++; $display("FAIL rd_access r=%0d got=%b exp=1100", r, {o_psel, o_penable, o_pwrite, o_res_valid}); end
            step();
            exp = {16'hC0DE, 16'(base + r)};
            for (int s = 0; s <= ((r == stall_idx) ? stall_n : 0); s++) begin
                if (s == ((r == stall_idx) ? stall_n : 0)) i_res_ready = 1'b1;
                #1;
                checks++; if ({o_res_valid, o_psel} !== 2'b10 || o_res_data !== exp || o_res_last !== (r == 3)) begin
                    errs++; $display("FAIL rd_hold r=%0d s=%0d valid/psel=%b data=%h last=%b exp 10 data=%h last=%b",
                                     r, s, {o_res_valid, o_psel}, o_res_data, o_res_last, exp, (r == 3)); end
                step();
            end
            i_res_ready = 1'b0;
        end
        checks++; if ({o_job_ready, o_busy, o_psel} !== 3'b100) begin
            errs++; $display("FAIL drain_end got=%b exp=100", {o_job_ready, o_busy, o_psel}); end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_job_valid = 1'b0; i_job_w = '0; i_job_nvec = '0; i_job_keep_w = 1'b0;
        i_vec_valid = 1'b0; i_vec_a = '0; i_vec_b = '0; i_res_ready = 1'b0; i_in_full = 2'b00; i_done = 1'b0;
        step(); step();
        i_rst = 1'b0;
        checks++; if (any_out !== 1'b0 || o_job_ready !== 1'b1) begin
            errs++; $display("FAIL reset_outs any=%b ready=%b exp any=0 ready=1", any_out, o_job_ready); end
    endtask

    task automatic test_basic();
        send_job({32'd4, 32'd3, 32'd2, 32'd1}, 4'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if ({o_psel, o_penable, o_pwrite} !== 3'b101 || o_paddr !== AW'(i) || o_pwdata !== DW'(i + 1)) begin
                errs++; $display("FAIL wr_setup i=%0d got=%b %h %h exp 101 %h %h", i, {o_psel, o_penable, o_pwrite}, o_paddr, o_pwdata, i, i + 1); end
            step();
            checks++; if ({o_psel, o_penable, o_pwrite} !== 3'b111 || o_paddr !== AW'(i) || o_pwdata !== DW'(i + 1)) begin
                errs++; $display("FAIL wr_access i=%0d got=%b %h %h exp 111 %h %h", i, {o_psel, o_penable, o_pwrite}, o_paddr, o_pwdata, i, i + 1); end
            step();
        end
        checks++; if ({o_psel, o_busy, o_start} !== 3'b010) begin
            errs++; $display("FAIL feed_entry got=%b exp=010", {o_psel, o_busy, o_start}); end
        for (int p = 0; p < 4; p++) begin
            i_vec_valid = 1'b1; i_vec_a = DW'(2*p + 1); i_vec_b = DW'(2*p + 2);
            #1;
            checks++; if ({o_vec_ready, o_in_en} !== 2'b11 || o_in1 !== DW'(2*p + 1) || o_in2 !== DW'(2*p + 2)) begin
                errs++; $display("FAIL push p=%0d got=%b %h %h exp 11 %h %h", p, {o_vec_ready, o_in_en}, o_in1, o_in2, 2*p + 1, 2*p + 2); end
            step();
        end
        i_vec_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) i_done = 1'b1;
            #1;
            checks++; if ({o_start, o_in_en, o_psel} !== 3'b100) begin
                errs++; $display("FAIL run c=%0d got=%b exp=100", c, {o_start, o_in_en, o_psel}); end
            step();
        end
        i_done = 1'b0;
        checks++; if (o_start !== 1'b0) begin errs++; $display("FAIL start_drop got=%b exp=0", o_start); end
        drain(-1, 0);
    endtask

    task automatic test_fifo_full();
        send_job('0, 4'd3, 1'b1);
        i_vec_valid = 1'b1; i_vec_a = 32'd10; i_vec_b = 32'd11;
        #1;
        checks++; if ({o_in_en, o_in1, o_in2} !== {1'b1, 32'd10, 32'd11}) begin
            errs++; $display("FAIL ff_push0 got=%b %h %h exp 1 a b", o_in_en, o_in1, o_in2); end
        step();
        i_vec_a = 32'd12; i_vec_b = 32'd13; i_in_full = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if ({o_vec_ready, o_in_en, o_busy} !== 3'b001) begin
                errs++; $display("FAIL ff_blocked c=%0d got=%b exp=001", c, {o_vec_ready, o_in_en, o_busy}); end
            step();
        end
        i_in_full = 2'b00;
        for (int p = 1; p < 3; p++) begin
            i_vec_a = DW'(10 + 2*p); i_vec_b = DW'(11 + 2*p);
            #1;
            checks++; if ({o_vec_ready, o_in_en} !== 2'b11 || o_in1 !== DW'(10 + 2*p) || o_in2 !== DW'(11 + 2*p)) begin
                errs++; $display("FAIL ff_push p=%0d got=%b %h %h exp 11 %h %h", p, {o_vec_ready, o_in_en}, o_in1, o_in2, 10 + 2*p, 11 + 2*p); end
            step();
        end
        i_vec_valid = 1'b0;
        #1;
        checks++; if ({o_start, o_in_en} !== 2'b10) begin
            errs++; $display("FAIL ff_run got=%b exp=10", {o_start, o_in_en}); end
        i_done = 1'b1; step(); i_done = 1'b0;
        drain(-1, 0);
    endtask

    task automatic test_keep_stall();
        i_vec_valid = 1'b1; i_vec_a = 32'hDEAD; i_vec_b = 32'hBEEF;
        send_job({32'hF, 32'hF, 32'hF, 32'hF}, 4'd0, 1'b1);
        #1;
        checks++; if ({o_start, o_psel, o_in_en, o_busy} !== 4'b1001) begin
            errs++; $display("FAIL keep_run got=%b exp=1001", {o_start, o_psel, o_in_en, o_busy}); end
        i_vec_valid = 1'b0;
        i_done = 1'b1; step(); i_done = 1'b0;
        drain(1, 3);
    endtask

    task automatic test_timeout();
        send_job('0, 4'd0, 1'b1);
        for (int c = 0; c < 16; c++) begin
            checks++; if ({o_start, o_err, o_busy, o_psel} !== 4'b1010) begin
                errs++; $display("FAIL to_run c=%0d got=%b exp=1010", c, {o_start, o_err, o_busy, o_psel}); end
            step();
        end
        checks++; if ({o_start, o_err, o_busy, o_job_ready, o_psel} !== 5'b01010) begin
            errs++; $display("FAIL to_abort got=%b exp=01010", {o_start, o_err, o_busy, o_job_ready, o_psel}); end
        step(); step();
        checks++; if ({o_err, o_psel} !== 2'b10) begin errs++; $display("FAIL to_sticky got=%b exp=10", {o_err, o_psel}); end
        send_job('0, 4'd0, 1'b1);
        checks++; if ({o_err, o_start} !== 2'b01) begin errs++; $display("FAIL to_clear got=%b exp=01", {o_err, o_start}); end
        // done on the 16th RUN cycle must win over the timeout
        for (int c = 0; c < 15; c++) step();
        i_done = 1'b1; step(); i_done = 1'b0;
        checks++; if ({o_err, o_start, o_psel} !== 3'b001) begin
            errs++; $display("FAIL to_done_wins got=%b exp=001", {o_err, o_start, o_psel}); end
        drain(-1, 0);
    endtask

    task automatic test_mid_reset();
        send_job({32'd8, 32'd7, 32'd6, 32'd5}, 4'd1, 1'b0);
        step();
        checks++; if ({o_psel, o_penable} !== 2'b11) begin errs++; $display("FAIL mr_waccess got=%b exp=11", {o_psel, o_penable}); end
        i_rst = 1'b1; step(); i_rst = 1'b0;
        checks++; if (any_out !== 1'b0 || o_job_ready !== 1'b1) begin
            errs++; $display("FAIL mr_w_outs any=%b ready=%b exp 0 1", any_out, o_job_ready); end
        step();
        checks++; if ({o_psel, o_busy} !== 2'b00) begin errs++; $display("FAIL mr_w_quiet got=%b exp=00", {o_psel, o_busy}); end
        send_job('0, 4'd0, 1'b1);
        i_done = 1'b1; step(); i_done = 1'b0;
        step(); step();
        checks++; if (o_res_valid !== 1'b1) begin errs++; $display("FAIL mr_rhold got=%b exp=1", o_res_valid); end
        i_rst = 1'b1; step(); i_rst = 1'b0;
        checks++; if (any_out !== 1'b0 || o_job_ready !== 1'b1) begin
            errs++; $display("FAIL mr_r_outs any=%b ready=%b exp 0 1", any_out, o_job_ready); end
    endtask

    task automatic test_back_to_back();
        send_job('0, 4'd1, 1'b1);
        i_vec_valid = 1'b1; i_vec_a = 32'd20; i_vec_b = 32'd21;
        #1;
        checks++; if ({o_in_en, o_in1, o_in2} !== {1'b1, 32'd20, 32'd21}) begin
            errs++; $display("FAIL b2b_push got=%b %h %h exp 1 14 15", o_in_en, o_in1, o_in2); end
        step();
        i_vec_valid = 1'b0;
        i_done = 1'b1; step(); i_done = 1'b0;
        drain(-1, 0);
        send_job({32'd8, 32'd7, 32'd6, 32'd5}, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++; if ({o_psel, o_penable, o_pwrite} !== {2'b10 | 2'(i % 2), 1'b1} || o_paddr !== AW'(i / 2) || o_pwdata !== DW'(5 + i / 2)) begin
                errs++; $display("FAIL b2b_wr i=%0d got=%b %h %h exp addr %h data %h", i, {o_psel, o_penable, o_pwrite}, o_paddr, o_pwdata, i / 2, 5 + i / 2); end
            step();
        end
        checks++; if ({o_start, o_psel} !== 2'b10) begin errs++; $display("FAIL b2b_run got=%b exp=10", {o_start, o_psel}); end
        i_done = 1'b1; step(); i_done = 1'b0;
        drain(-1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_full();
        test_keep_stall();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errs, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tpu_job_ctrl.md
Name: tpu_job_ctrl

Overview:
- Job sequencer in front of tpu_top. It takes one job descriptor from a host: four 2x2 weights, a vector count and a weight-reuse flag.
- It then drives tpu_top through its phases in order: APB weight writes (addresses 0..3), pushing input pairs into the in1/in2 FIFOs, start/done, and draining results by four APB reads of address 0.
- Replaces hand-sequenced APB and FIFO traffic with one valid/ready job interface and one valid/ready result stream.

Parameters:
- DW, 32, data width of weights, vectors, APB data and results.
- AW, 32, APB address width.
- CNT_W, 4, width of the vector count (up to 15 vectors per job).
- N_RES, 4, APB reads of address 0 per job.
- TIMEOUT, 1024, maximum cycles in RUN waiting for i_done before abort.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_job_valid  in  1  job descriptor valid.
- o_job_ready  out  1  high only in IDLE.
- i_job_w  in  4*DW  weights; [DW-1:0]=W00, then W01, W10, W11.
- i_job_nvec  in  CNT_W  number of input pairs to push.
- i_job_keep_w  in  1  1 = skip the weight load and reuse the loaded weights.
- i_vec_valid  in  1  input pair valid.
- o_vec_ready  out  1  pair accepted this cycle when both valid and ready are high.
- i_vec_a  in  DW  in1 value.
- i_vec_b  in  DW  in2 value.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result consumer ready.
- o_res_data  out  DW  captured prdata.
- o_res_last  out  1  marks the N_RES-th result.
- o_in1  out  DW  to tpu in1.
- o_in2  out  DW  to tpu in2.
- o_in_en  out  1  drives both in1_en and in2_en.
- i_in_full  in  2  bit0 = in1 FIFO full, bit1 = in2 FIFO full.
- o_start  out  1  tpu start.
- i_done  in  1  tpu done.
- o_paddr  out  AW  APB address.
- o_psel  out  1  APB select.
- o_penable  out  1  APB enable.
- o_pwrite  out  1  APB write.
- o_pwdata  out  DW  APB write data.
- i_prdata  in  DW  APB read data.
- o_busy  out  1  state is not IDLE.
- o_err  out  1  sticky timeout flag.

Behaviour:
- Reset (i_rst high at a clock edge): state IDLE, all counters 0, every output 0 except o_job_ready=1. The reset applies mid-operation with no further APB or FIFO activity. tpu_top is not reset by this block.
- States: IDLE, WSETUP, WACCESS, FEED, RUN, RSETUP, RACCESS, RHOLD.
- IDLE, job accept: on i_job_valid & o_job_ready, latch the descriptor and clear o_err.
  - Next state is WSETUP if i_job_keep_w=0.
  - Otherwise FEED if nvec>0.
  - Otherwise RUN.
- Weight load:
  - WSETUP drives psel=1, penable=0, pwrite=1, paddr=widx, pwdata=weight[widx].
  - WACCESS keeps the same signals with penable=1.
  - No pready: each transfer is exactly 2 cycles, so the full load is 8 cycles.
  - After widx=3, go to FEED if nvec>0, else RUN.
  - psel=0 in every other state.
- FEED:
  - o_vec_ready = i_in_full==2'b00.
  - o_in_en = i_vec_valid & o_vec_ready, combinational, with o_in1/o_in2 = i_vec_a/i_vec_b in the same cycle.
  - Both FIFOs are always pushed together. No push while either FIFO is full.
  - Go to RUN after the nvec-th push. i_vec_valid is ignored outside FEED.
- RUN:
  - o_start is registered high from the first RUN cycle and held until i_done is sampled high. It is then low the next cycle and the state moves to RSETUP.
  - A cycle counter counts RUN cycles. When it reaches TIMEOUT with no done: set o_err, drop o_start, go to IDLE, skip the drain.
  - i_done arriving in the same cycle as the timeout: done wins.
- Drain, per result:
  - RSETUP: psel=1, pwrite=0, paddr=0.
  - RACCESS: penable=1; i_prdata is captured at the end of RACCESS.
  - RHOLD: o_res_valid=1 with stable data; o_res_last=1 on result N_RES.
  - The next read does not start until i_res_ready is high in RHOLD.
  - After the last handshake, go to IDLE.
- o_busy = state!=IDLE. o_err is held until the next job is accepted.

Decomposition:
- Shared package tpu_pkg holds:
  - the state enum;
  - APB address constants ADDR_W00..ADDR_W11 (0..3) and ADDR_RES (0);
  - the DW default.
- One natural sub-module, tpu_apb_xfer: a 2-phase APB master single-transfer engine with req/addr/wdata/write inputs and done/rdata outputs. Shared by the weight-load and drain phases.

Test Plan:
- Job w={1,2,3,4}, nvec=4, pairs (1,2)(3,4)(5,6)(7,8):
  - 4 APB writes at addr 0..3 with data 1..4, 2 cycles each, psel never gaps in the middle of a transfer;
  - 4 o_in_en pulses carrying those pairs;
  - o_start until done;
  - 4 reads of addr 0 with results equal to the bench model's prdata, last flagged on the 4th.
- i_in_full=2'b10 held for 5 cycles during FEED -> no o_in_en and o_vec_ready=0 for those 5 cycles; after release, remaining pairs pushed in order with no loss or duplication.
- i_job_keep_w=1, nvec=0 -> no APB writes and no pushes; o_start in the first cycle after accept; 4 reads follow done.
- i_res_ready low for 3 cycles on result 2 -> o_res_valid/o_res_data stable and no APB activity until the handshake.
- i_done never asserted, TIMEOUT=16 -> o_start drops after 16 RUN cycles; o_err=1; back in IDLE with no reads; o_err clears on the next accept.
- i_rst pulsed during WACCESS and during RHOLD -> the next cycle shows all outputs 0 and o_job_ready=1; the next job runs normally.
